// File: rtl/arm_alu_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : arm_alu_seq_pkg
//  Brief    : Shared opcode constants, FSM encodings, NZCV bit indices and
//             opcode-class helpers for the ARM ALU sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
package arm_alu_seq_pkg;

    // ARM data-processing opcodes
    localparam logic [3:0] c_op_and = 4'h0;
    localparam logic [3:0] c_op_eor = 4'h1;
    localparam logic [3:0] c_op_sub = 4'h2;
    localparam logic [3:0] c_op_rsb = 4'h3;
    localparam logic [3:0] c_op_add = 4'h4;
    localparam logic [3:0] c_op_adc = 4'h5;
    localparam logic [3:0] c_op_sbc = 4'h6;
    localparam logic [3:0] c_op_rsc = 4'h7;
    localparam logic [3:0] c_op_tst = 4'h8;
    localparam logic [3:0] c_op_teq = 4'h9;
    localparam logic [3:0] c_op_cmp = 4'hA;
    localparam logic [3:0] c_op_cmn = 4'hB;
    localparam logic [3:0] c_op_orr = 4'hC;
    localparam logic [3:0] c_op_mov = 4'hD;
    localparam logic [3:0] c_op_bic = 4'hE;
    localparam logic [3:0] c_op_mvn = 4'hF;

    // NZCV bit positions inside the 4-bit flag register
    localparam int c_flag_n = 3;
    localparam int c_flag_z = 2;
    localparam int c_flag_c = 1;
    localparam int c_flag_v = 0;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PASS1 = 2'd1,
        ST_PASS2 = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Arithmetic shape of an opcode: how carry and overflow are derived
    typedef enum logic [1:0] {
        CLS_LOGIC = 2'd0,
        CLS_ADD   = 2'd1,   // rn + op2
        CLS_SUB   = 2'd2,   // rn - op2
        CLS_RSB   = 2'd3    // op2 - rn
    } op_class_t;

    function automatic logic is_logical(input logic [3:0] op);
        return op inside {c_op_and, c_op_eor, c_op_tst, c_op_teq,
                          c_op_orr, c_op_mov, c_op_bic, c_op_mvn};
    endfunction

    // Compare/test ops: always update flags, never write a register
    function automatic logic is_test(input logic [3:0] op);
        return op inside {c_op_tst, c_op_teq, c_op_cmp, c_op_cmn};
    endfunction

    function automatic logic needs_carry(input logic [3:0] op);
        return op inside {c_op_adc, c_op_sbc, c_op_rsc};
    endfunction

    function automatic op_class_t op_class(input logic [3:0] op);
        op_class_t cls;
        case (op)
            c_op_add, c_op_adc, c_op_cmn: cls = CLS_ADD;
            c_op_sub, c_op_sbc, c_op_cmp: cls = CLS_SUB;
            c_op_rsb, c_op_rsc:           cls = CLS_RSB;
            default:                      cls = CLS_LOGIC;
        endcase
        return cls;
    endfunction

    // Carry-less equivalent of a carry-using opcode
    function automatic logic [3:0] base_op(input logic [3:0] op);
        logic [3:0] res;
        case (op)
            c_op_adc: res = c_op_add;
            c_op_sbc: res = c_op_sub;
            c_op_rsc: res = c_op_rsb;
            default:  res = op;
        endcase
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/arm_flag_gen.sv
`default_nettype none
// ============================================================================
//  Module   : arm_flag_gen
//  Brief    : Combinational next-NZCV generator. N/Z from the final result,
//             C from the sequencer carry (arithmetic) or shifter carry
//             (logical), V from operand/result signs or held (logical).
//  Revision : 1.0 - initial release
// ============================================================================
module arm_flag_gen
    import arm_alu_seq_pkg::*;
(
    input  logic [31:0] result,
    input  logic        op_a_sign,
    input  logic        op_b_sign,
    input  op_class_t   cls,
    input  logic        carry,
    input  logic        shift_c,
    input  logic        old_v,
    output logic [3:0]  nzcv
);

    // Overflow is judged on the original operation, not the carry-adjust pass
    always_comb begin
        nzcv           = 4'b0000;
        nzcv[c_flag_n] = result[31];
        nzcv[c_flag_z] = (result == 32'd0);
        case (cls)
            CLS_ADD: begin
                nzcv[c_flag_c] = carry;
                nzcv[c_flag_v] = (op_a_sign == op_b_sign) && (result[31] != op_a_sign);
            end
            CLS_SUB: begin
                nzcv[c_flag_c] = carry;
                nzcv[c_flag_v] = (op_a_sign != op_b_sign) && (result[31] != op_a_sign);
            end
            CLS_RSB: begin
                nzcv[c_flag_c] = carry;
                nzcv[c_flag_v] = (op_a_sign != op_b_sign) && (result[31] != op_b_sign);
            end
            default: begin
                nzcv[c_flag_c] = shift_c;
                nzcv[c_flag_v] = old_v;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/arm_alu_seq.sv
`default_nettype none
// ============================================================================
//  Module   : arm_alu_seq
//  Brief    : Multi-cycle sequencer for the shared 32-bit ARM ALU. Drives the
//             ALU buses for one or two passes, derives NZCV, holds the flag
//             register and presents the result on a valid/ready interface.
//  Config   : ARM_ALU_SEQ_CARRY_EN - when defined, ADC/SBC/RSC take a second
//             pass to fold in the carry; otherwise they run as ADD/SUB/RSB.
//  Revision : 1.0 - initial release
// ============================================================================
module arm_alu_seq
    import arm_alu_seq_pkg::*;
#(
    parameter logic [3:0] FLAGS_RESET = 4'b0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_opcode,
    input  logic        in_s,
    input  logic [31:0] in_rn_val,
    input  logic [31:0] in_op2,
    input  logic        in_shift_c,
    input  logic [3:0]  in_rd,
    output logic [31:0] alu_op1,
    output logic [31:0] alu_op2,
    output logic [3:0]  alu_op_sel,
    input  logic [31:0] alu_out,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [3:0]  out_rd,
    output logic        out_wr_en,
    output logic [3:0]  flags
);

    state_t      r_state;
    logic [3:0]  r_opcode;
    logic        r_s;
    logic [31:0] r_rn;
    logic [31:0] r_op2;
    logic        r_shift_c;
    logic [3:0]  r_rd;
    logic [31:0] r_result;
    logic        r_carry;
    logic        r_wr_en;
    logic        r_out_valid;
    logic [3:0]  r_flags;

    logic [32:0] w_sum1;
    logic        w_c1;
    op_class_t   w_class;
    logic [3:0]  w_nzcv_next;
    logic        w_flag_we;

`ifdef ARM_ALU_SEQ_CARRY_EN
    logic        r_cin;
    logic        w_is_adc;
    logic        w_c_final;
`endif

    assign w_class   = op_class(r_opcode);
    assign w_sum1    = {1'b0, r_rn} + {1'b0, r_op2};
    assign w_flag_we = r_s || is_test(r_opcode);

    // First-pass carry: adder carry-out, or no-borrow from an unsigned compare
    always_comb begin
        w_c1 = 1'b0;
        case (w_class)
            CLS_ADD: w_c1 = w_sum1[32];
            CLS_SUB: w_c1 = (r_rn >= r_op2);
            CLS_RSB: w_c1 = (r_op2 >= r_rn);
            default: w_c1 = 1'b0;
        endcase
    end

`ifdef ARM_ALU_SEQ_CARRY_EN
    assign w_is_adc = (r_opcode == c_op_adc);

    // Second-pass carry merge: ADC carries if either pass did; SBC/RSC only
    // avoid a borrow if neither pass borrowed (r1 - ~cin borrows iff r1 < ~cin)
    always_comb begin
        if (w_is_adc) begin
            w_c_final = r_carry | ((&r_result) & r_cin);
        end else begin
            w_c_final = r_carry & ~((r_result == 32'd0) & ~r_cin);
        end
    end
`endif

    // ALU bus drive: operands only during the passes, zero otherwise
    always_comb begin
        alu_op1    = 32'd0;
        alu_op2    = 32'd0;
        alu_op_sel = 4'd0;
        case (r_state)
            ST_PASS1: begin
                alu_op1 = r_rn;
                alu_op2 = r_op2;
`ifdef ARM_ALU_SEQ_CARRY_EN
                alu_op_sel = r_opcode;
`else
                alu_op_sel = base_op(r_opcode);
`endif
            end
`ifdef ARM_ALU_SEQ_CARRY_EN
            ST_PASS2: begin
                alu_op1 = r_result;
                if (w_is_adc) begin
                    alu_op2    = {31'd0, r_cin};
                    alu_op_sel = c_op_add;
                end else begin
                    alu_op2    = {31'd0, ~r_cin};
                    alu_op_sel = c_op_sub;
                end
            end
`endif
            default: begin
                alu_op1    = 32'd0;
                alu_op2    = 32'd0;
                alu_op_sel = 4'd0;
            end
        endcase
    end

    arm_flag_gen u_flag_gen (
        .result    (r_result),
        .op_a_sign (r_rn[31]),
        .op_b_sign (r_op2[31]),
        .cls       (w_class),
        .carry     (r_carry),
        .shift_c   (r_shift_c),
        .old_v     (r_flags[c_flag_v]),
        .nzcv      (w_nzcv_next)
    );

    // Sequencer FSM: accept, run one or two ALU passes, hold result until taken
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_opcode    <= 4'd0;
            r_s         <= 1'b0;
            r_rn        <= 32'd0;
            r_op2       <= 32'd0;
            r_shift_c   <= 1'b0;
            r_rd        <= 4'd0;
            r_result    <= 32'd0;
            r_carry     <= 1'b0;
            r_wr_en     <= 1'b0;
            r_out_valid <= 1'b0;
            r_flags     <= FLAGS_RESET;
`ifdef ARM_ALU_SEQ_CARRY_EN
            r_cin       <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_opcode  <= in_opcode;
                        r_s       <= in_s;
                        r_rn      <= in_rn_val;
                        r_op2     <= in_op2;
                        r_shift_c <= in_shift_c;
                        r_rd      <= in_rd;
                        r_wr_en   <= ~is_test(in_opcode);
`ifdef ARM_ALU_SEQ_CARRY_EN
                        r_cin     <= r_flags[c_flag_c];
`endif
                        r_state   <= ST_PASS1;
                    end
                end
                ST_PASS1: begin
                    r_result <= alu_out;
                    r_carry  <= w_c1;
`ifdef ARM_ALU_SEQ_CARRY_EN
                    if (needs_carry(r_opcode)) begin
                        r_state <= ST_PASS2;
                    end else begin
                        r_state     <= ST_DONE;
                        r_out_valid <= 1'b1;
                    end
`else
                    r_state     <= ST_DONE;
                    r_out_valid <= 1'b1;
`endif
                end
`ifdef ARM_ALU_SEQ_CARRY_EN
                ST_PASS2: begin
                    r_result    <= alu_out;
                    r_carry     <= w_c_final;
                    r_state     <= ST_DONE;
                    r_out_valid <= 1'b1;
                end
`endif
                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                        if (w_flag_we) begin
                            r_flags <= w_nzcv_next;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready   = (r_state == ST_IDLE);
    assign out_valid  = r_out_valid;
    assign out_result = r_result;
    assign out_rd     = r_rd;
    assign out_wr_en  = r_wr_en;
    assign flags      = r_flags;

endmodule
`default_nettype wire

// File: doc/arm_alu_seq.md
# arm_alu_seq

Multi-cycle sequencer for the shared 32-bit ARM ALU in the execute stage. It accepts one decoded data-processing instruction at a time and drives the ALU operand and opcode buses for one or two passes. It derives NZCV flags that the ALU does not produce, maintains the flag register, and hands the result to writeback through a valid/ready handshake.

## Interface
Parameters:
- `FLAGS_RESET`, default 4'b0000: NZCV value loaded on reset.

Ports:
- `clk`  in  1  system clock; one clock domain.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  decoded instruction present.
- `in_ready`  out  1  sequencer can accept; high only in IDLE.
- `in_opcode`  in  4  ARM DP opcode: AND=0 EOR=1 SUB=2 RSB=3 ADD=4 ADC=5 SBC=6 RSC=7 TST=8 TEQ=9 CMP=A CMN=B ORR=C MOV=D BIC=E MVN=F.
- `in_s`  in  1  S bit; update flags.
- `in_rn_val`  in  32  first operand.
- `in_op2`  in  32  shifter output.
- `in_shift_c`  in  1  shifter carry-out, used for logical ops.
- `in_rd`  in  4  destination register.
- `alu_op1`, `alu_op2`  out  32  ALU operand buses.
- `alu_op_sel`  out  4  ALU opcode.
- `alu_out`  in  32  combinational ALU result.
- `out_valid`  out  1  result ready for writeback.
- `out_ready`  in  1  writeback accepts.
- `out_result`  out  32  final result.
- `out_rd`  out  4  destination register.
- `out_wr_en`  out  1  low for TST/TEQ/CMP/CMN.
- `flags`  out  4  NZCV register, bit 3 = N.

## Operation
- The FSM has four states: IDLE, PASS1, PASS2, DONE.
- IDLE -> PASS1 on `in_valid`. On this edge the block latches the opcode, S bit, operands, `in_shift_c`, rd, and the current C flag (`cin`).
- PASS1 drives `alu_op1`=rn, `alu_op2`=op2, and `alu_op_sel`=opcode, then registers `alu_out` as r1.
  - It computes carry c1 with a 33-bit internal add or compare.
  - ADD/CMN: c1 = bit 32 of rn+op2.
  - SUB/CMP: c1 = (rn >= op2).
  - RSB: c1 = (op2 >= rn).
- PASS1 -> PASS2 for ADC/SBC/RSC; PASS1 -> DONE for all other opcodes.
- PASS2 adjusts r1 by the latched carry:
  - ADC: drive op1=r1, op2={31'b0,cin}, sel=ADD. C = c1|c2.
  - SBC/RSC: drive op1=r1, op2={31'b0,~cin}, sel=SUB. C = c1&c2, where c2 = no-borrow.
- Flags computed from the final result and the original operands:
  - N = result[31]. Z = (result==0).
  - Arithmetic ops: C as above. V = signed overflow of the original operation (rn+op2, rn-op2, or op2-rn), using operand signs and result sign.
  - Logical ops (AND EOR TST TEQ ORR MOV BIC MVN): C = latched `in_shift_c`; V unchanged.
- DONE holds `out_valid`=1 with stable outputs until `out_ready`, then returns to IDLE.
- `flags` is written at the DONE handshake edge, only when S=1 or the opcode is TST/TEQ/CMP/CMN.
- Outside PASS1/PASS2, the ALU buses are driven to 0 with sel=0.

## Timing
- Accept to `out_valid`: 2 cycles for single-pass ops, 3 for ADC/SBC/RSC.
- Minimum initiation interval is 3 cycles (single-pass) or 4 cycles (two-pass); there is no accept in the cycle after a handshake.
- `in_ready` depends only on state; it is not combinational on `out_ready`.
- `in_valid` is ignored outside IDLE.
- Reset, including in the middle of an operation: state=IDLE and any in-flight op is discarded. All outputs are 0 except `in_ready`=1 and `flags`=FLAGS_RESET.
- Arithmetic wraps modulo 2^32.

## Configuration
- `ARM_ALU_SEQ_CARRY_EN`
  - Defined: ADC/SBC/RSC perform PASS2 with carry, as above.
  - Undefined: PASS2 is removed. ADC/SBC/RSC execute as ADD/SUB/RSB in a single pass, and C/V come from PASS1 only.

## Structure
- A shared package holds:
  - the 4-bit opcode constants;
  - FSM state encodings;
  - NZCV bit-index constants;
  - `is_logical`, `is_test`, and `needs_carry` opcode class helpers.
- One sub-module, `arm_flag_gen`, is natural. It is combinational: from result, operands, operation class, carries, and old flags, it produces next NZCV.

## Test plan
- ADD, S=1, rn=FFFFFFFF, op2=1 -> `out_result`=0, `flags`=0110 (Z,C) after 2 cycles, `out_wr_en`=1.
- CMP rn=5, op2=7 -> `out_wr_en`=0, `flags`=1000 (N, no C), `out_result`=FFFFFFFE.
- ADC, C=1, rn=7FFFFFFF, op2=0 -> 3-cycle latency, result 80000000, `flags`=1001 (N,V).
- SBC, C=0, rn=10, op2=3 -> result 0000000C, C=1; in a build without `ARM_ALU_SEQ_CARRY_EN`, result 0000000D with 2-cycle latency.
- MOVS op2=0, `in_shift_c`=1, V preset 1 -> `flags`=0111. Hold `out_ready`=0 for 5 cycles: outputs stable, `in_ready`=0, a new `in_valid` is ignored.
- Assert `reset` during PASS2 -> `out_valid` never rises, `flags`=FLAGS_RESET, `in_ready`=1 immediately.
